// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline definitions: controller states, NOP encoding,
// PC increment and target word-alignment helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_REDIR = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_fetch_ctrl_if.sv
// Fetch-control bundle: hazard/redirect requests in, PC and IF/ID controls out.
interface pipe_fetch_ctrl_if;
    import pipe_pkg::*;

    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic        if_id_we;
    logic        if_id_flush;
    logic        fetch_valid;
    logic        misalign;

    modport master (
        output stall, br_taken, br_target, jmp, jmp_target,
        input  pc, if_id_we, if_id_flush, fetch_valid, misalign
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target,
        output pc, if_id_we, if_id_flush, fetch_valid, misalign
    );

endinterface

// File: rtl/fetch_redir_cnt.sv
// Post-redirect bubble down-counter with load, hold (dec low) and zero flag.
module fetch_redir_cnt
    import pipe_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Bubble count register; saturates at zero
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage PC sequencing and IF/ID control with post-redirect bubbles.
// Define FETCH_STAT_EN to add the stat_fetch / stat_bubble counters.
module pipe_fetch_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          REDIR_BUBBLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    pipe_fetch_ctrl_if.slave fif
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]      stat_fetch,
    output logic [31:0]      stat_bubble
`endif
);

    localparam logic [1:0] BUB_LOAD = 2'(REDIR_BUBBLES - 1);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic         redir_s;
    logic [31:0]  tgt_s;
    logic         cnt_load_s;
    logic         cnt_dec_s;
    logic         cnt_zero_s;
    logic         we_s;
    logic         flush_s;
    logic         fv_s;
    logic         mis_s;

    // Redirect request decode; a taken branch outranks a simultaneous jump
    always_comb begin
        redir_s = fif.br_taken | fif.jmp;
        if (fif.br_taken) begin
            tgt_s = fif.br_target;
        end else begin
            tgt_s = fif.jmp_target;
        end
    end

    // Next-state, next-PC and per-cycle control outputs
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        we_s        = 1'b0;
        flush_s     = 1'b0;
        fv_s        = 1'b0;
        mis_s       = 1'b0;
        if (clr) begin
            state_nxt_s = ST_BOOT;
            pc_nxt_s    = RESET_PC;
            flush_s     = 1'b1;
        end else if (state_r == ST_BOOT) begin
            // Redirects are ignored while the first fetch is being set up
            we_s    = 1'b1;
            flush_s = 1'b1;
            if (fif.stall) begin
                state_nxt_s = ST_HOLD;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else if (redir_s) begin
            state_nxt_s = ST_REDIR;
            pc_nxt_s    = word_align(tgt_s);
            cnt_load_s  = 1'b1;
            we_s        = 1'b1;
            flush_s     = 1'b1;
            mis_s       = (tgt_s[1:0] != 2'b00);
        end else begin
            case (state_r)
                ST_RUN: begin
                    we_s = 1'b1;
                    fv_s = 1'b1;
                    if (fif.stall) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        pc_nxt_s = pc_r + PC_INC;
                    end
                end
                ST_HOLD: begin
                    if (fif.stall) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_RUN;
                        pc_nxt_s    = pc_r + PC_INC;
                    end
                end
                ST_REDIR: begin
                    we_s    = 1'b1;
                    flush_s = 1'b1;
                    if (fif.stall) begin
                        state_nxt_s = ST_REDIR;
                    end else if (cnt_zero_s) begin
                        state_nxt_s = ST_RUN;
                        pc_nxt_s    = pc_r + PC_INC;
                    end else begin
                        cnt_dec_s = 1'b1;
                        pc_nxt_s  = pc_r + PC_INC;
                    end
                end
                default: begin
                    state_nxt_s = ST_BOOT;
                    pc_nxt_s    = RESET_PC;
                    flush_s     = 1'b1;
                end
            endcase
        end
    end

    // State and PC registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_BOOT;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    fetch_redir_cnt #(
        .W (2)
    ) u_redir_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load_s),
        .load_val (BUB_LOAD),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    assign fif.pc          = pc_r;
    assign fif.if_id_we    = we_s;
    assign fif.if_id_flush = flush_s;
    assign fif.fetch_valid = fv_s;
    assign fif.misalign    = mis_s;

`ifdef FETCH_STAT_EN
    // Fetch and bubble statistics, cleared by clr and wrapping at 2^32
    always_ff @(posedge clk) begin
        if (clr) begin
            stat_fetch  <= 32'd0;
            stat_bubble <= 32'd0;
        end else begin
            if (fv_s) begin
                stat_fetch <= stat_fetch + 32'd1;
            end else begin
                stat_fetch <= stat_fetch;
            end
            if (flush_s || (state_r == ST_HOLD)) begin
                stat_bubble <= stat_bubble + 32'd1;
            end else begin
                stat_bubble <= stat_bubble;
            end
        end
    end
`endif

endmodule
